encoder_8_to_3_sync: RTL and testbench
======================================

ENCODER_8_TO_3_SYNC -- requirements
Module: encoder_8_to_3_sync

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous active-high reset, sampled on rising clk edge.
REQ-003 G  input  1  enable; 1 = encoding active, 0 = block forced idle.
REQ-004 I  input  8  request lines, I[7] highest priority; synchronous to clk, no internal synchronizer.
REQ-005 ack  input  1  consumer acknowledge of the presented code.
REQ-006 Y  output  3  binary index of the captured highest-priority request bit.
REQ-007 V  output  1  code valid; Y is meaningful while V=1.
REQ-008 M  output  1  multi-hit flag; captured I had more than one bit set.
REQ-009 busy  output  1  1 in any state other than IDLE.
REQ-010 cnt  output  8  count of codes acknowledged since reset.
REQ-011 All outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Function
REQ-012 The FSM SHALL have states IDLE, VALID, RELEASE.
REQ-013 IDLE: when G=1 and I!=0 at a clk edge, the block SHALL load Y = index of the highest set bit of I, load M = (popcount(I)>1), set V=1, and enter VALID at that same edge.
REQ-014 Latency: V and Y SHALL be visible in the cycle immediately after the edge at which I was sampled (1 cycle).
REQ-015 IDLE with I=0 or G=0: the block SHALL remain in IDLE, V=0; Y and M hold their last values.
REQ-016 VALID: Y, M, V=1 SHALL hold stable regardless of changes on I until ack=1 is sampled.
REQ-017 VALID with ack=1: the block SHALL clear V, increment cnt by 1, and enter RELEASE at that edge.
REQ-018 cnt SHALL wrap 255 -> 0 without flag or saturation.
REQ-019 ack sampled while V=0 SHALL be ignored (no state change, no cnt increment).
REQ-020 RELEASE: the block SHALL stay in RELEASE while I!=0 and return to IDLE at the first edge where I=0 is sampled; no capture occurs in that cycle.
REQ-021 A request held continuously across ack SHALL therefore not be re-captured until I goes to 0 for at least one sampled cycle.
REQ-022 G=0 sampled in any state SHALL force IDLE and V=0 at that edge; Y, M, cnt hold; G=0 takes priority over ack in the same cycle (no cnt increment).
REQ-023 Priority mapping SHALL be: I[7]->7, I[6]->6, ... I[0]->0; lower bits ignored when a higher bit is set.
REQ-024 busy SHALL equal 1 in VALID and RELEASE, 0 in IDLE.

Reset
REQ-025 rst=1 at a clk edge SHALL set state=IDLE, Y=3'b000, V=0, M=0, busy=0, cnt=8'h00, overriding G, I and ack.
REQ-026 rst asserted mid-operation (VALID or RELEASE) SHALL abort the transaction with no cnt increment; after rst deasserts, a still-asserted I SHALL be captured from IDLE per REQ-013.

Verification
REQ-027 Reset: rst=1 one cycle with G=1, I=8'hFF, ack=1 -> next cycle Y=0, V=0, M=0, busy=0, cnt=0.
REQ-028 Single capture: G=1, I=8'b0010_0000 one cycle -> next cycle Y=5, V=1, M=0, busy=1; I changes to 8'h01 -> Y stays 5; ack=1 -> V=0, cnt=1.
REQ-029 Priority/multi-hit: I=8'b1000_0101 -> Y=7, M=1; separately I=8'h03 -> Y=1, M=1.
REQ-030 Release hold: I=8'h10 held through ack and 5 further cycles -> no second V pulse, cnt=1; I=0 one cycle then I=8'h10 -> second capture, cnt=2 after ack.
REQ-031 Enable/simultaneous: in VALID drive G=0 and ack=1 same cycle -> V=0, state IDLE, cnt unchanged; ack with V=0 -> no cnt change.
REQ-032 Wrap: 256 complete capture/ack/release sequences -> cnt reads 255 after the 255th ack and 0 after the 256th.

Source files
------------

// File: rtl/encoder_8_to_3_sync.sv
// Registered 8-to-3 priority encoder with valid/ack handshake.
// A captured code is held until acknowledged; the request must drop before re-capture.
module encoder_8_to_3_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       G,
  input  logic [7:0] I,
  input  logic       ack,
  output logic [2:0] Y,
  output logic       V,
  output logic       M,
  output logic       busy,
  output logic [7:0] cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VALID   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] y_nxt;
  logic       v_nxt;
  logic       m_nxt;
  logic [7:0] cnt_nxt;

  // Highest set bit wins because later iterations overwrite earlier ones.
  function automatic logic [2:0] prio_index(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (req[b]) idx = b[2:0];
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Y     <= 3'd0;
      V     <= 1'b0;
      M     <= 1'b0;
      busy  <= 1'b0;
      cnt   <= 8'h00;
    end else begin
      state <= state_nxt;
      Y     <= y_nxt;
      V     <= v_nxt;
      M     <= m_nxt;
      busy  <= (state_nxt != IDLE);
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    y_nxt     = Y;
    v_nxt     = V;
    m_nxt     = M;
    cnt_nxt   = cnt;

    // Disable overrides everything, including an ack in the same cycle.
    if (!G) begin
      state_nxt = IDLE;
      v_nxt     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I != 8'h00) begin
            y_nxt     = prio_index(I);
            m_nxt     = ((I & (I - 8'd1)) != 8'h00);
            v_nxt     = 1'b1;
            state_nxt = VALID;
          end
        end
        VALID: begin
          if (ack) begin
            v_nxt     = 1'b0;
            cnt_nxt   = cnt + 8'd1;
            state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          if (I == 8'h00) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          v_nxt     = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_8_to_3_sync.sv
// Directed self-checking bench for encoder_8_to_3_sync.
// Each step drives inputs, clocks once, then compares all outputs 1 time unit later.
module tb_encoder_8_to_3_sync;

  logic       clk;
  logic       rst;
  logic       G;
  logic [7:0] I;
  logic       ack;
  logic [2:0] Y;
  logic       V;
  logic       M;
  logic       busy;
  logic [7:0] cnt;

  int vectors;
  int miscompares;

  encoder_8_to_3_sync dut (
    .clk (clk),
    .rst (rst),
    .G   (G),
    .I   (I),
    .ack (ack),
    .Y   (Y),
    .V   (V),
    .M   (M),
    .busy(busy),
    .cnt (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic g, input logic [7:0] req, input logic a);
    rst = r;
    G   = g;
    I   = req;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] ey, input logic ev,
                             input logic em, input logic eb, input logic [7:0] ec);
    logic [13:0] obs;
    logic [13:0] exp_v;
    obs   = {Y, V, M, busy, cnt};
    exp_v = {ey, ev, em, eb, ec};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed Y=%0d V=%b M=%b busy=%b cnt=%0d, expected Y=%0d V=%b M=%b busy=%b cnt=%0d",
             tag, Y, V, M, busy, cnt, ey, ev, em, eb, ec);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; G = 1'b0; I = 8'h00; ack = 1'b0;

    // Reset overrides active G, I and ack
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
    checkOutput("reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("idle_no_req", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Single capture, hold against changing I, ack
    applyStimulus(1'b0, 1'b1, 8'b0010_0000, 1'b0);
    checkOutput("capture_bit5", 3'd5, 1'b1, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    checkOutput("hold_bit5", 3'd5, 1'b1, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b1);
    checkOutput("ack_bit5", 3'd5, 1'b0, 1'b0, 1'b1, 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("release_to_idle", 3'd5, 1'b0, 1'b0, 1'b0, 8'd1);

    // Priority and multi-hit
    applyStimulus(1'b0, 1'b1, 8'b1000_0101, 1'b0);
    checkOutput("capture_85", 3'd7, 1'b1, 1'b1, 1'b1, 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("ack_85", 3'd7, 1'b0, 1'b1, 1'b1, 8'd2);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("idle_after_85", 3'd7, 1'b0, 1'b1, 1'b0, 8'd2);
    applyStimulus(1'b0, 1'b1, 8'h03, 1'b0);
    checkOutput("capture_03", 3'd1, 1'b1, 1'b1, 1'b1, 8'd2);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("ack_03", 3'd1, 1'b0, 1'b1, 1'b1, 8'd3);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("idle_after_03", 3'd1, 1'b0, 1'b1, 1'b0, 8'd3);

    // Request held through ack is not re-captured; ack during release ignored
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0);
    checkOutput("capture_10", 3'd4, 1'b1, 1'b0, 1'b1, 8'd3);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b1);
    checkOutput("ack_10", 3'd4, 1'b0, 1'b0, 1'b1, 8'd4);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 8'h10, (k == 2));
      checkOutput($sformatf("release_hold_%0d", k), 3'd4, 1'b0, 1'b0, 1'b1, 8'd4);
    end
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("release_drop", 3'd4, 1'b0, 1'b0, 1'b0, 8'd4);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0);
    checkOutput("recapture_10", 3'd4, 1'b1, 1'b0, 1'b1, 8'd4);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("ack_recapture", 3'd4, 1'b0, 1'b0, 1'b1, 8'd5);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("idle_after_recap", 3'd4, 1'b0, 1'b0, 1'b0, 8'd5);

    // G=0 beats ack; ack in idle ignored; G=0 blocks capture
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b0);
    checkOutput("capture_40", 3'd6, 1'b1, 1'b0, 1'b1, 8'd5);
    applyStimulus(1'b0, 1'b0, 8'h40, 1'b1);
    checkOutput("g0_with_ack", 3'd6, 1'b0, 1'b0, 1'b0, 8'd5);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("ack_while_idle", 3'd6, 1'b0, 1'b0, 1'b0, 8'd5);
    applyStimulus(1'b0, 1'b0, 8'h80, 1'b0);
    checkOutput("g0_blocks_capture", 3'd6, 1'b0, 1'b0, 1'b0, 8'd5);

    // G=0 in release returns to idle, so a held request is captured again
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
    checkOutput("capture_02", 3'd1, 1'b1, 1'b0, 1'b1, 8'd5);
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b1);
    checkOutput("ack_02", 3'd1, 1'b0, 1'b0, 1'b1, 8'd6);
    applyStimulus(1'b0, 1'b0, 8'h02, 1'b0);
    checkOutput("g0_in_release", 3'd1, 1'b0, 1'b0, 1'b0, 8'd6);
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
    checkOutput("capture_after_g0", 3'd1, 1'b1, 1'b0, 1'b1, 8'd6);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("ack_after_g0", 3'd1, 1'b0, 1'b0, 1'b1, 8'd7);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("idle_after_g0", 3'd1, 1'b0, 1'b0, 1'b0, 8'd7);

    // Reset mid-transaction aborts, then held request is captured
    applyStimulus(1'b0, 1'b1, 8'h08, 1'b0);
    checkOutput("capture_08", 3'd3, 1'b1, 1'b0, 1'b1, 8'd7);
    applyStimulus(1'b1, 1'b1, 8'h08, 1'b1);
    checkOutput("reset_mid_op", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'h08, 1'b0);
    checkOutput("capture_post_reset", 3'd3, 1'b1, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("ack_post_reset", 3'd3, 1'b0, 1'b0, 1'b1, 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("idle_post_reset", 3'd3, 1'b0, 1'b0, 1'b0, 8'd1);

    // Counter wrap over 256 full transactions
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
    checkOutput("reset_before_wrap", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] req;
      logic [7:0] exp_cnt;
      req     = 8'h01 << (k % 8);
      exp_cnt = k[7:0];
      applyStimulus(1'b0, 1'b1, req, 1'b0);
      checkOutput($sformatf("wrap_capture_%0d", k), 3'(k % 8), 1'b1, 1'b0, 1'b1, exp_cnt);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
      exp_cnt = exp_cnt + 8'd1;
      checkOutput($sformatf("wrap_ack_%0d", k), 3'(k % 8), 1'b0, 1'b0, 1'b1, exp_cnt);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    end
    checkOutput("wrap_final", 3'd7, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
